// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, register index, write-back select and entry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [2:0] {
    WB_ALU, WB_MEM, WB_NPC, WB_LUI,
    WB_LB,  WB_LBU, WB_LH,  WB_LHU
  } wb_sel_t;

  typedef struct packed {
    regbits_t dst;
    word_t    dat;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Per-channel write-back FIFO with a per-slot valid/dst view for hazard tracking.
module wb_fifo
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WB_ENTRY_W-1:0]   din_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [WB_ENTRY_W-1:0]   head_o,
  output logic [DEPTH-1:0]        vld_o,
  output logic [DEPTH*5-1:0]      dst_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    rd_q, wr_q;
  logic [DEPTH-1:0] vld_q, vld_d;
  wb_entry_t        mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = &vld_q;
  assign empty_o = ~|vld_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];
  assign vld_o   = vld_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_dst
    assign dst_o[i*5 +: 5] = mem_q[i].dst;
  end

  always_comb begin
    vld_d = vld_q;
    if (do_pop)  vld_d[rd_q] = 1'b0;
    if (do_push) vld_d[wr_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wb_entry_t'(din_i);
  end

endmodule

// File: rtl/write_back_unit.sv
// Multi-channel write-back: per-channel FIFOs, round-robin drain, pending mask.
// Define WB_LOAD_EXT_EN to enable LB/LBU/LH/LHU extraction on regSel 4..7.
module write_back_unit
  import cpu_types_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wben,
  input  logic [NCH-1:0]    ch_valid,
  output logic [NCH-1:0]    ch_ready,
  input  logic [NCH-1:0]    ch_regWr,
  input  logic [NCH*3-1:0]  ch_regSel,
  input  logic [NCH*5-1:0]  ch_regDst,
  input  logic [NCH*32-1:0] ch_nPC,
  input  logic [NCH*32-1:0] ch_ALUOut,
  input  logic [NCH*32-1:0] ch_lui,
  input  logic [NCH*32-1:0] ch_dmemload,
  output logic              WEN,
  output logic [4:0]        wsel,
  output logic [31:0]       wdat,
  output logic [31:0]       pend_mask
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  function automatic word_t sel_data(logic [2:0] sel, word_t alu,
                                     word_t mem, word_t npc, word_t lui);
    word_t r;
`ifdef WB_LOAD_EXT_EN
    word_t sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = mem >> {~alu[1:0], 3'b000};
    b  = sh[7:0];
    h  = alu[1] ? mem[15:0] : mem[31:16];
`endif
    r = mem;
    case (wb_sel_t'(sel))
      WB_ALU: r = alu;
      WB_NPC: r = npc;
      WB_LUI: r = lui;
`ifdef WB_LOAD_EXT_EN
      WB_LB:  r = {{24{b[7]}}, b};
      WB_LBU: r = {24'b0, b};
      WB_LH:  r = {{16{h[15]}}, h};
      WB_LHU: r = {16'b0, h};
`endif
      default: r = mem;
    endcase
    return r;
  endfunction

  logic [NCH-1:0]        push, pop, full, empty;
  logic [WB_ENTRY_W-1:0] head [NCH];
  logic [DEPTH-1:0]      vld  [NCH];
  logic [DEPTH*5-1:0]    dsts [NCH];

  assign ch_ready = ~full;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    wb_entry_t din;
    assign din.dst = ch_regDst[c*5 +: 5];
    assign din.dat = sel_data(ch_regSel[c*3 +: 3],
                              ch_ALUOut[c*32 +: 32],
                              ch_dmemload[c*32 +: 32],
                              ch_nPC[c*32 +: 32],
                              ch_lui[c*32 +: 32]);
    // dst=0 or regWr=0 completes the handshake but queues nothing
    assign push[c] = ch_valid[c] && ch_ready[c] && ch_regWr[c]
                     && (din.dst != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .din_i   (din),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .head_o  (head[c]),
      .vld_o   (vld[c]),
      .dst_o   (dsts[c])
    );
  end

  logic [PW-1:0] ptr_q, ptr_d, gnt;
  logic          found, drain;
  wb_entry_t     hd;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NCH;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        gnt   = PW'(idx);
      end
    end
  end

  assign drain = wben && found;
  assign pop   = drain ? (NCH'(1) << gnt) : '0;
  assign ptr_d = drain ? gnt : ptr_q;
  assign hd    = wb_entry_t'(head[gnt]);
  assign WEN   = drain;
  assign wsel  = drain ? hd.dst : '0;
  assign wdat  = drain ? hd.dat : '0;

  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= PW'(NCH - 1);
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    pend_mask = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (vld[c][e]) pend_mask[dsts[c][e*5 +: 5]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

endmodule
